serial_sub4: RTL and testbench

SERIAL_SUB4 -- requirements
Module: serial_sub4

---
 rtl/serial_sub4.sv | 131 +++++++++++++
 tb/tb_serial_sub4.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// The result is published only when the last bit is done, so diff never shows partial bits.
module serial_sub4 #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_diff,
    output logic         o_bout
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_brw;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_diff;
    logic          r_bout;

    logic          w_aBit;
    logic          w_bBit;
    logic          w_dBit;
    logic          w_brwNext;
    logic          w_lastBit;
    logic          w_accept;
    logic [W:0]    w_accWide;
    logic [W-1:0]  w_accNext;
    logic          w_busy;
    logic          w_done;

    assign w_aBit    = r_a[0];
    assign w_bBit    = r_b[0];
    assign w_dBit    = w_aBit ^ w_bBit ^ r_brw;
    assign w_brwNext = (~w_aBit & w_bBit) | (~(w_aBit ^ w_bBit) & r_brw);
    assign w_lastBit = (r_cnt == CW'(W - 1));
    assign w_accept  = i_start && ((r_state == IDLE) || (r_state == DONE));

    // New bits enter at the top so that after W shifts bit 0 sits at the LSB.
    assign w_accWide = {w_dBit, r_acc};
    assign w_accNext = w_accWide[W:1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_lastBit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (i_start) begin
                    w_nextState = RUN;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Operands are shifted out LSB first; the start input is ignored while running.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_brw <= i_bin;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_brw <= w_brwNext;
            r_acc <= w_accNext;
            r_cnt <= r_cnt + CW'(1);
            if (w_lastBit) begin
                r_diff <= w_accNext;
                r_bout <= w_brwNext;
            end
        end
    end

    assign o_busy = w_busy;
    assign o_done = w_done;
    assign o_diff = r_diff;
    assign o_bout = r_bout;

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: directed cases, reset abort, exhaustive and random
// operations compared against an arithmetic reference model.
module tb_serial_sub4;

    localparam int W = 4;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_bin;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_diff;
    logic         o_bout;

    int assertCount;
    int failCount;
    int lastDiff;
    int lastBout;

    serial_sub4 #(.W(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_bin   (i_bin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_diff  (o_diff),
        .o_bout  (o_bout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: true integer difference; the low W bits are diff, a negative value means borrow.
    function automatic int refDiff(input int a, input int b, input int bin);
        int full;
        full = a - b - bin;
        return ((full % (1 << W)) + (1 << W)) % (1 << W);
    endfunction

    function automatic int refBout(input int a, input int b, input int bin);
        return (a - b - bin < 0) ? 1 : 0;
    endfunction

    task automatic idleCycles(input int n);
        i_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            checkOutput("idle busy", int'(o_busy), 0);
            checkOutput("idle done", int'(o_done), 0);
            checkOutput("idle diff held", int'(o_diff), lastDiff);
            checkOutput("idle bout held", int'(o_bout), lastBout);
        end
    endtask

    // Called on a negedge; returns on the negedge of the DONE cycle so a caller may chain.
    task automatic applyStimulus(input int a, input int b, input int bin, input bit holdStart);
        int expDiff;
        int expBout;
        expDiff = refDiff(a, b, bin);
        expBout = refBout(a, b, bin);
        i_a     = W'(a);
        i_b     = W'(b);
        i_bin   = bin[0];
        i_start = 1'b1;
        @(posedge i_clk);
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge i_clk);
            if (k <= W) begin
                checkOutput("run busy", int'(o_busy), 1);
                checkOutput("run done", int'(o_done), 0);
                checkOutput("run diff hidden", int'(o_diff), lastDiff);
                checkOutput("run bout hidden", int'(o_bout), lastBout);
                i_a     = W'($urandom);
                i_b     = W'($urandom);
                i_bin   = 1'($urandom);
                i_start = holdStart;
            end else begin
                checkOutput("done busy", int'(o_busy), 0);
                checkOutput("done pulse", int'(o_done), 1);
                checkOutput("result diff", int'(o_diff), expDiff);
                checkOutput("result bout", int'(o_bout), expBout);
            end
        end
        lastDiff = expDiff;
        lastBout = expBout;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        lastDiff    = 0;
        lastBout    = 0;
        i_rst_n     = 1'b0;
        i_start     = 1'b1;
        i_a         = '1;
        i_b         = '1;
        i_bin       = 1'b1;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("reset busy", int'(o_busy), 0);
        checkOutput("reset done", int'(o_done), 0);
        checkOutput("reset diff", int'(o_diff), 0);
        checkOutput("reset bout", int'(o_bout), 0);
        i_rst_n = 1'b1;
        idleCycles(3);

        applyStimulus(5, 3, 0, 1'b0);
        idleCycles(2);
        applyStimulus(0, 1, 0, 1'b0);
        idleCycles(1);
        applyStimulus(8, 0, 1, 1'b0);
        idleCycles(2);

        // Start held through RUN and into DONE chains straight into the next operation.
        applyStimulus(12, 7, 1, 1'b1);
        applyStimulus(3, 9, 0, 1'b1);
        applyStimulus(15, 15, 1, 1'b0);
        idleCycles(2);

        // Reset during the second RUN cycle aborts the operation without a done pulse.
        i_a     = 4'd9;
        i_b     = 4'd2;
        i_bin   = 1'b0;
        i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        checkOutput("abort run1 busy", int'(o_busy), 1);
        @(negedge i_clk);
        checkOutput("abort run2 busy", int'(o_busy), 1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        checkOutput("abort busy", int'(o_busy), 0);
        checkOutput("abort done", int'(o_done), 0);
        checkOutput("abort diff", int'(o_diff), 0);
        checkOutput("abort bout", int'(o_bout), 0);
        lastDiff = 0;
        lastBout = 0;
        idleCycles(W + 2);
        applyStimulus(15, 1, 0, 1'b0);
        idleCycles(1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bin = 0; bin < 2; bin++) begin
                    applyStimulus(a, b, bin, 1'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        idleCycles(1);
                    end
                end
            end
        end
        idleCycles(1);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 1)), 1'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                idleCycles(int'($urandom_range(1, 3)));
            end
        end
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
